// File: rtl/scan_sel_gen.sv
// ---------------------------------------------------------------------------
// scan_sel_gen
//
// Generates a 2-bit scan select code for a downstream 2-to-4 decoder. The
// code advances (up or down) once every div+1 enabled RUN cycles. The scan can
// be frozen (HOLD), stopped (IDLE), or have its code loaded directly.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   scan enable; low forces IDLE
//   hold_req   in   freeze the scan (RUN <-> HOLD)
//   dir        in   0 = count up, 1 = count down (sampled in the tick cycle)
//   load       in   synchronous load of the select code
//   load_val   in   code to load; bit 1 -> i0, bit 0 -> i1
//   div        in   prescale divisor; advance every div+1 RUN cycles
//   i0, i1     out  select MSB / LSB (registered)
//   step       out  one-cycle pulse in the cycle the code takes a new value
//   wrap       out  pulse with step when the advance wraps (3->0 / 0->3)
//   busy       out  high while in RUN
// ---------------------------------------------------------------------------
module scan_sel_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             hold_req,
  input  logic             dir,
  input  logic             load,
  input  logic [1:0]       load_val,
  input  logic [DIV_W-1:0] div,
  output logic             i0,
  output logic             i1,
  output logic             step,
  output logic             wrap,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [DIV_W-1:0] pcnt_q, pcnt_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             busy_q, busy_d;

  logic             tick;
  logic [1:0]       sel_adv;
  logic             adv_wrap;

  // Terminal tick uses >= so that lowering div below the running count
  // still produces a tick on the next RUN cycle instead of counting on
  // until the counter wraps around.
  assign tick     = (state_q == ST_RUN) && (pcnt_q >= div);
  assign sel_adv  = dir ? (sel_q - 2'd1) : (sel_q + 2'd1);
  assign adv_wrap = dir ? (sel_q == 2'd0) : (sel_q == 2'd3);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pcnt_d  = pcnt_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;

    // en low dominates every other transition.
    if (!en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = hold_req ? ST_HOLD : ST_RUN;
        ST_RUN:  state_d = hold_req ? ST_HOLD : ST_RUN;
        ST_HOLD: state_d = hold_req ? ST_HOLD : ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end

    // Prescaler and advance are evaluated in the current state, so a tick
    // in the same cycle that hold_req or en changes still completes.
    case (state_q)
      ST_RUN:  pcnt_d = tick ? '0 : pcnt_q + DIV_W'(1);
      ST_HOLD: pcnt_d = pcnt_q;
      default: pcnt_d = '0;
    endcase

    if (tick) begin
      sel_d  = sel_adv;
      step_d = 1'b1;
      wrap_d = adv_wrap;
    end

    // Load overrides any advance but leaves the state machine alone.
    if (load) begin
      sel_d  = load_val;
      pcnt_d = '0;
      step_d = 1'b0;
      wrap_d = 1'b0;
    end

    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      pcnt_q  <= '0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pcnt_q  <= pcnt_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
    end
  end

  assign i0   = sel_q[1];
  assign i1   = sel_q[0];
  assign step = step_q;
  assign wrap = wrap_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// ---------------------------------------------------------------------------
// tb_scan_sel_gen
//
// Directed bench for scan_sel_gen. Inputs change on the falling edge and
// outputs are sampled on the falling edge, so each check reflects the state
// after the preceding rising edge. Expected values are hand-derived.
// ---------------------------------------------------------------------------
module tb_scan_sel_gen;

  localparam int DIV_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             hold_req;
  logic             dir;
  logic             load;
  logic [1:0]       load_val;
  logic [DIV_W-1:0] div;
  logic             i0, i1, step, wrap, busy;

  int n_checks;
  int n_errors;

  scan_sel_gen #(.DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .hold_req (hold_req),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .div      (div),
    .i0       (i0),
    .i1       (i1),
    .step     (step),
    .wrap     (wrap),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end else begin
      $display("ok   %s: %b", tag, got);
    end
  endtask

  // Compare {i0,i1,step,wrap,busy} against an expected vector.
  task automatic chk_out(input string tag, input logic [1:0] sel_e,
                         input logic step_e, input logic wrap_e, input logic busy_e);
    check(tag, {3'b000, i0, i1, step, wrap, busy},
               {3'b000, sel_e, step_e, wrap_e, busy_e});
  endtask

  // Advance one rising edge, then check at the following falling edge.
  task automatic cyc(input string tag, input logic [1:0] sel_e,
                     input logic step_e, input logic wrap_e, input logic busy_e);
    @(negedge clk);
    chk_out(tag, sel_e, step_e, wrap_e, busy_e);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;
    en       = 1'b0;
    hold_req = 1'b0;
    dir      = 1'b0;
    load     = 1'b0;
    load_val = 2'b00;
    div      = '0;

    // Asynchronous reset, checked before any rising edge.
    #1 rst_n = 1'b0;
    #1 chk_out("reset_async", 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("reset_held", 2'b00, 1'b0, 1'b0, 1'b0);

    // Count up, div = 0: a new code every cycle, wrap only on 11->00.
    rst_n = 1'b1;
    en    = 1'b1;
    cyc("up_enter_run", 2'b00, 1'b0, 1'b0, 1'b1);
    cyc("up_01",        2'b01, 1'b1, 1'b0, 1'b1);
    cyc("up_10",        2'b10, 1'b1, 1'b0, 1'b1);
    cyc("up_11",        2'b11, 1'b1, 1'b0, 1'b1);
    cyc("up_wrap_00",   2'b00, 1'b1, 1'b1, 1'b1);

    // Load 00 while dropping en: load beats the tick, state goes IDLE.
    en = 1'b0; load = 1'b1; load_val = 2'b00;
    cyc("load_to_idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // Count down, div = 3: first advance 4 cycles after RUN entry.
    load = 1'b0; en = 1'b1; dir = 1'b1; div = 8'd3;
    cyc("dn_enter_run", 2'b00, 1'b0, 1'b0, 1'b1);
    cyc("dn_p1",        2'b00, 1'b0, 1'b0, 1'b1);
    cyc("dn_p2",        2'b00, 1'b0, 1'b0, 1'b1);
    cyc("dn_p3",        2'b00, 1'b0, 1'b0, 1'b1);
    cyc("dn_wrap_11",   2'b11, 1'b1, 1'b1, 1'b1);
    cyc("dn_q1",        2'b11, 1'b0, 1'b0, 1'b1);
    cyc("dn_q2",        2'b11, 1'b0, 1'b0, 1'b1);
    cyc("dn_q3",        2'b11, 1'b0, 1'b0, 1'b1);
    cyc("dn_10",        2'b10, 1'b1, 1'b0, 1'b1);

    // Hold after pcnt reaches 2: pcnt freezes at 3 during HOLD.
    dir = 1'b0;
    cyc("pre_hold_p1", 2'b10, 1'b0, 1'b0, 1'b1);
    cyc("pre_hold_p2", 2'b10, 1'b0, 1'b0, 1'b1);
    hold_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc($sformatf("hold_%0d", k), 2'b10, 1'b0, 1'b0, 1'b0);
    end
    hold_req = 1'b0;
    cyc("resume_run", 2'b10, 1'b0, 1'b0, 1'b1);
    cyc("resume_adv", 2'b11, 1'b1, 1'b0, 1'b1);

    // Load coincident with tick: load wins, no step/wrap.
    cyc("ld_p1", 2'b11, 1'b0, 1'b0, 1'b1);
    cyc("ld_p2", 2'b11, 1'b0, 1'b0, 1'b1);
    cyc("ld_p3", 2'b11, 1'b0, 1'b0, 1'b1);
    load = 1'b1; load_val = 2'b10;
    cyc("ld_on_tick", 2'b10, 1'b0, 1'b0, 1'b1);
    load = 1'b0;
    cyc("ld_q1",  2'b10, 1'b0, 1'b0, 1'b1);
    cyc("ld_q2",  2'b10, 1'b0, 1'b0, 1'b1);
    cyc("ld_q3",  2'b10, 1'b0, 1'b0, 1'b1);
    cyc("ld_adv", 2'b11, 1'b1, 1'b0, 1'b1);

    // en dropped mid-count at sel=01, then re-raised: full 4 cycles.
    load = 1'b1; load_val = 2'b01;
    cyc("ld_01", 2'b01, 1'b0, 1'b0, 1'b1);
    load = 1'b0;
    cyc("en_p1", 2'b01, 1'b0, 1'b0, 1'b1);
    en = 1'b0;
    cyc("en_off_idle", 2'b01, 1'b0, 1'b0, 1'b0);
    cyc("en_off_keep", 2'b01, 1'b0, 1'b0, 1'b0);
    en = 1'b1;
    cyc("en_on_run", 2'b01, 1'b0, 1'b0, 1'b1);
    cyc("en_on_p1",  2'b01, 1'b0, 1'b0, 1'b1);
    cyc("en_on_p2",  2'b01, 1'b0, 1'b0, 1'b1);
    cyc("en_on_p3",  2'b01, 1'b0, 1'b0, 1'b1);
    cyc("en_on_adv", 2'b10, 1'b1, 1'b0, 1'b1);

    // Reach 11, then pulse reset between clock edges.
    cyc("rs_p1",  2'b10, 1'b0, 1'b0, 1'b1);
    cyc("rs_p2",  2'b10, 1'b0, 1'b0, 1'b1);
    cyc("rs_p3",  2'b10, 1'b0, 1'b0, 1'b1);
    cyc("rs_11",  2'b11, 1'b1, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_out("rst_mid_scan", 2'b00, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    cyc("rst_restart", 2'b00, 1'b0, 1'b0, 1'b1);
    cyc("rst_p1",      2'b00, 1'b0, 1'b0, 1'b1);
    cyc("rst_p2",      2'b00, 1'b0, 1'b0, 1'b1);
    cyc("rst_p3",      2'b00, 1'b0, 1'b0, 1'b1);
    cyc("rst_adv_01",  2'b01, 1'b1, 1'b0, 1'b1);

    // Lower div below the running count: tick on the next RUN cycle.
    cyc("dl_p1", 2'b01, 1'b0, 1'b0, 1'b1);
    cyc("dl_p2", 2'b01, 1'b0, 1'b0, 1'b1);
    div = 8'd1;
    cyc("dl_adv_10", 2'b10, 1'b1, 1'b0, 1'b1);
    cyc("dl_q1",     2'b10, 1'b0, 1'b0, 1'b1);
    cyc("dl_adv_11", 2'b11, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
